// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with default-master parking, burst tracking and
// locked-transfer hold. Grant moves only at arbitration points; HMASTER follows on the next ready edge.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_INCR   = 3'b001;

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    typedef enum logic [1:0] {
        ST_PARK   = 2'b00,
        ST_OWN    = 2'b01,
        ST_BURST  = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             beats_reg, beats_next;
    logic [MW-1:0]          owner_reg, owner_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [MW-1:0]          master_reg;
    logic                   mastlock_reg;

    logic                   is_idle, is_nonseq, is_seq;
    logic [3:0]             load_val;
    logic                   owner_lock, arb_point;
    logic [MW-1:0]          cand_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] cand_hit;
    logic                   found;
    logic [MW-1:0]          sel_idx;

    assign is_idle    = (HTRANS == TR_IDLE);
    assign is_nonseq  = (HTRANS == TR_NONSEQ);
    assign is_seq     = (HTRANS == TR_SEQ);
    assign owner_lock = HLOCK[owner_reg];

    always_comb begin
        load_val = 4'd0;
        case (HBURST[2:1])
            2'b00:   load_val = 4'd0;
            2'b01:   load_val = 4'd3;
            2'b10:   load_val = 4'd7;
            default: load_val = 4'd15;
        endcase
    end

    // A SEQ inside a locked sequence never releases the bus, even on its last beat.
    assign arb_point = HREADY && !owner_lock && !(state_reg == ST_LOCKED && is_seq) &&
                       (is_idle ||
                        (is_nonseq && load_val == 4'd0) ||
                        (is_seq && beats_reg == 4'd1) ||
                        (HBURST == BU_INCR && (is_nonseq || is_seq)));

    // Candidate gi is the (gi+1)-th master after the owner; the owner itself is checked last.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            assign cand_idx[gi] = MW'((int'(owner_reg) + 1 + gi) % NUM_MASTERS);
            assign cand_hit[gi] = HBUSREQ[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        sel_idx = DEF_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                found   = 1'b1;
                sel_idx = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        beats_next = beats_reg;
        owner_next = owner_reg;
        if (HREADY) begin
            if (is_nonseq)
                beats_next = load_val;
            else if (is_seq && beats_reg != 4'd0)
                beats_next = beats_reg - 4'd1;
            else if (is_idle)
                beats_next = 4'd0;

            if (owner_lock) begin
                state_next = ST_LOCKED;
            end else if (arb_point) begin
                owner_next = found ? sel_idx : DEF_IDX;
                state_next = found ? ST_OWN : ST_PARK;
            end else if (is_nonseq && load_val != 4'd0) begin
                state_next = ST_BURST;
            end else if (state_reg == ST_LOCKED && !is_seq) begin
                state_next = ST_OWN;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
            assign grant_next[gi] = (owner_next == MW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_PARK;
            beats_reg    <= 4'd0;
            owner_reg    <= DEF_IDX;
            grant_reg    <= DEF_GRANT;
            master_reg   <= DEF_IDX;
            mastlock_reg <= 1'b0;
        end else if (HREADY) begin
            state_reg    <= state_next;
            beats_reg    <= beats_next;
            owner_reg    <= owner_next;
            grant_reg    <= grant_next;
            master_reg   <= owner_reg;
            mastlock_reg <= HLOCK[owner_reg];
        end
    end

    assign HGRANT    = grant_reg;
    assign HMASTER   = master_reg;
    assign HMASTLOCK = mastlock_reg;

endmodule
